// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use interlock, branch kill,
// exception flush, MDU occupancy of EXE, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MDU_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        exe_mem_read,
    input  logic [4:0]  exe_wb_dreg,
    input  logic        exe_wb_we,
    input  logic        exe_bj,
    input  logic        exe_mdu,
    input  logic        exc_req,
    input  logic        perf_clr,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_exe_en,
    output logic        id_exe_flush,
    output logic        exe_mem_flush,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MDU_LAT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] stall_reg;
    logic        load_use;
    logic        rs_hit, rt_hit;

    assign rs_hit   = id_use_rs && (exe_wb_dreg == id_rs);
    assign rt_hit   = id_use_rt && (exe_wb_dreg == id_rt);
    assign load_use = exe_mem_read && exe_wb_we && (exe_wb_dreg != 5'd0) && (rs_hit || rt_hit);

    // Strobes are evaluated in strict priority: exception, MDU occupancy, branch, load-use.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_exe_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        mdu_busy      = 1'b0;
        mdu_done      = 1'b0;
        state_next    = state_reg;
        cnt_next      = cnt_reg;

        if (exc_req) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
            state_next    = RUN;
            cnt_next      = 4'd0;
        end else if (state_reg == BUSY && cnt_reg != 4'd0) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_flush = 1'b1;
            mdu_busy      = 1'b1;
            cnt_next      = cnt_reg - 4'd1;
        end else if (state_reg == BUSY) begin
            // Final MDU cycle: the op leaves EXE even though exe_mdu is still high.
            mdu_done      = 1'b1;
            mdu_busy      = 1'b1;
            state_next    = RUN;
        end else if (exe_mdu) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_flush = 1'b1;
            state_next    = BUSY;
            cnt_next      = LAT_M1;
        end else if (exe_bj) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
        end else if (load_use) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RUN;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Clear wins over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_reg <= 16'd0;
        end else if (perf_clr) begin
            stall_reg <= 16'd0;
        end else if (!pc_en && stall_reg != 16'hFFFF) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-phase reference model.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, exe_wb_dreg;
    logic        id_use_rs, id_use_rt, exe_mem_read, exe_wb_we;
    logic        exe_bj, exe_mdu, exc_req, perf_clr;
    logic        pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush;
    logic        exe_mem_flush, mdu_busy, mdu_done;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // Model state: cycles already spent on the current MDU op (0 = none in flight).
    int mdu_phase = 0;
    int model_stall = 0;

    typedef struct packed {
        logic pc_en, if_id_en, id_exe_en, if_id_flush, id_exe_flush;
        logic exe_mem_flush, mdu_busy, mdu_done;
    } exp_t;

    hazard_ctrl #(.MDU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .exe_mem_read(exe_mem_read), .exe_wb_dreg(exe_wb_dreg), .exe_wb_we(exe_wb_we),
        .exe_bj(exe_bj), .exe_mdu(exe_mdu), .exc_req(exc_req), .perf_clr(perf_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_exe_en(id_exe_en), .id_exe_flush(id_exe_flush), .exe_mem_flush(exe_mem_flush),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit model_load_use();
        return exe_mem_read && exe_wb_we && (exe_wb_dreg != 0) &&
               ((id_use_rs && exe_wb_dreg == id_rs) || (id_use_rt && exe_wb_dreg == id_rt));
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        e.pc_en = 1; e.if_id_en = 1; e.id_exe_en = 1;
        if (exc_req) begin
            e.if_id_flush = 1; e.id_exe_flush = 1; e.exe_mem_flush = 1;
        end else if ((mdu_phase > 0 && mdu_phase < LAT) || (mdu_phase == 0 && exe_mdu)) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_exe_en = 0;
            e.exe_mem_flush = 1;
            e.mdu_busy = (mdu_phase > 0);
        end else if (mdu_phase == LAT) begin
            e.mdu_done = 1; e.mdu_busy = 1;
        end else if (exe_bj) begin
            e.if_id_flush = 1; e.id_exe_flush = 1;
        end else if (model_load_use()) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_exe_flush = 1;
        end
        return e;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        exp_t e;
        #1;
        e = model_out();
        chk("pc_en",         16'(pc_en),         16'(e.pc_en));
        chk("if_id_en",      16'(if_id_en),      16'(e.if_id_en));
        chk("id_exe_en",     16'(id_exe_en),     16'(e.id_exe_en));
        chk("if_id_flush",   16'(if_id_flush),   16'(e.if_id_flush));
        chk("id_exe_flush",  16'(id_exe_flush),  16'(e.id_exe_flush));
        chk("exe_mem_flush", 16'(exe_mem_flush), 16'(e.exe_mem_flush));
        chk("mdu_busy",      16'(mdu_busy),      16'(e.mdu_busy));
        chk("mdu_done",      16'(mdu_done),      16'(e.mdu_done));
        @(posedge clk);
        #1;
        if (exc_req)                mdu_phase = 0;
        else if (mdu_phase == LAT)  mdu_phase = 0;
        else if (mdu_phase > 0)     mdu_phase = mdu_phase + 1;
        else if (exe_mdu)           mdu_phase = 1;
        if (perf_clr)                           model_stall = 0;
        else if (!e.pc_en && model_stall < 65535) model_stall = model_stall + 1;
        chk("stall_cycles", stall_cycles, 16'(model_stall));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        exe_mem_read = 0; exe_wb_dreg = 0; exe_wb_we = 0;
        exe_bj = 0; exe_mdu = 0; exc_req = 0; perf_clr = 0;
    endtask

    task automatic set_load_use(input logic [4:0] dreg);
        exe_mem_read = 1; exe_wb_we = 1; exe_wb_dreg = dreg; id_rs = 5; id_use_rs = 1;
    endtask

    int frozen;

    initial begin
        idle_inputs();
        rst = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        $display("reset released");

        // Quiescent state after reset
        #1;
        chk("rst_pc_en", 16'(pc_en), 16'd1);
        chk("rst_flushes", 16'({if_id_flush, id_exe_flush, exe_mem_flush}), 16'd0);
        chk("rst_stall", stall_cycles, 16'd0);
        step();

        // Load-use on r5
        set_load_use(5);
        #1;
        chk("lu_pc_en", 16'(pc_en), 16'd0);
        chk("lu_id_exe_flush", 16'(id_exe_flush), 16'd1);
        step();
        chk("lu_stall_cnt", stall_cycles, 16'd1);
        $display("load-use r5: stall_cycles=%0d", stall_cycles);

        // $0 never stalls
        set_load_use(0); id_rs = 0;
        #1;
        chk("r0_pc_en", 16'(pc_en), 16'd1);
        step();
        $display("load-use r0: stall_cycles=%0d", stall_cycles);

        // MDU op held for the whole occupancy
        idle_inputs(); perf_clr = 1; step(); perf_clr = 0;
        exe_mdu = 1;
        frozen = 0;
        for (int i = 0; i < LAT; i++) begin
            #1;
            if (!pc_en && exe_mem_flush) frozen++;
            step();
        end
        chk("mdu_frozen_cycles", 16'(frozen), 16'(LAT));
        #1;
        chk("mdu_done_pulse", 16'({mdu_done, pc_en, if_id_en, id_exe_en}), 16'hF);
        step();
        exe_mdu = 0;
        #1;
        chk("mdu_back_run", 16'(mdu_busy), 16'd0);
        chk("mdu_stall_cnt", stall_cycles, 16'(LAT));
        step();
        $display("mdu op: frozen=%0d stall_cycles=%0d", frozen, stall_cycles);

        // Exception in the second BUSY cycle aborts the op
        exe_mdu = 1; step(); step();
        exc_req = 1;
        #1;
        chk("exc_flushes", 16'({if_id_flush, id_exe_flush, exe_mem_flush, pc_en}), 16'hF);
        step();
        exc_req = 0; exe_mdu = 0;
        #1;
        chk("exc_next_busy", 16'(mdu_busy), 16'd0);
        step();
        $display("exception mid-busy: mdu_busy=%0b", mdu_busy);

        // Branch beats load-use
        set_load_use(5); exe_bj = 1;
        #1;
        chk("bj_over_lu", 16'({if_id_flush, id_exe_flush, pc_en}), 16'h7);
        step();
        idle_inputs();
        $display("branch over load-use: pc_en=%0b", pc_en);

        // Asynchronous reset in the middle of BUSY
        exe_mdu = 1; step(); step();
        #2 rst = 0;
        #1;
        chk("areset_busy", 16'(mdu_busy), 16'd0);
        chk("areset_stall", stall_cycles, 16'd0);
        mdu_phase = 0; model_stall = 0;
        exe_mdu = 0;
        @(negedge clk);
        rst = 1;
        step();
        $display("async reset mid-busy: mdu_busy=%0b", mdu_busy);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom);
            id_use_rt    = 1'($urandom);
            exe_mem_read = 1'($urandom);
            exe_wb_we    = 1'($urandom);
            exe_wb_dreg  = 5'($urandom_range(0, 3));
            exe_bj       = ($urandom_range(0, 5) == 0);
            exc_req      = ($urandom_range(0, 19) == 0);
            perf_clr     = ($urandom_range(0, 49) == 0);
            exe_mdu      = (mdu_phase > 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            step();
        end
        idle_inputs();
        step();
        $display("random phase done: stall_cycles=%0d", stall_cycles);

        // Saturation of the stall counter, then clear during a stall
        perf_clr = 1; step(); perf_clr = 0;
        set_load_use(5);
        for (int i = 0; i < 65540; i++) step();
        chk("stall_saturated", stall_cycles, 16'hFFFF);
        $display("saturation: stall_cycles=%0h", stall_cycles);
        perf_clr = 1;
        step();
        perf_clr = 0;
        chk("stall_cleared", stall_cycles, 16'd0);
        $display("perf_clr during stall: stall_cycles=%0d", stall_cycles);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
